i2c_cmd_sequencer: RTL and testbench

//   Upstream command front-end for i2c_controller (master). Buffers I2C commands
//   {addr, rw, data} from a valid/ready stream in a small FIFO. Issues them one at a

---
 rtl/i2c_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: command FIFO plus issue FSM in front of an i2c_controller master.
// Commands {addr, rw, data} are queued and issued one at a time on the master pins.
// Each command produces exactly one response, either read data or a timeout flag.
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_rw,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [6:0] m_addr,
    output logic [7:0] m_data_in,
    output logic       m_rw,
    output logic       m_enable,
    input  logic [7:0] m_data_out,
    input  logic       m_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // FIFO storage, entry layout {addr[6:0], rw, data[7:0]}
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ready_en_q;
    logic          push, pop;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic          m_rw_q, m_rw_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_en_q, m_en_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_rw_q, rsp_rw_d;
    logic          rsp_to_q, rsp_to_d;

    assign cmd_ready   = ready_en_q & (count_q != FULL_CNT);
    assign push        = cmd_valid & cmd_ready;
    assign busy        = (state_q != ST_IDLE) | (count_q != '0);
    assign m_addr      = m_addr_q;
    assign m_rw        = m_rw_q;
    assign m_data_in   = m_data_q;
    assign m_enable    = m_en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rw      = rsp_rw_q;
    assign rsp_timeout = rsp_to_q;

    // FIFO occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO data storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_rw, cmd_data};
        end
    end

    // FIFO pointers, count and the post-reset enable for cmd_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Issue FSM next-state and output register values
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_data_d    = m_data_q;
        m_en_d      = m_en_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_to_d    = rsp_to_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && m_ready) begin
                    pop                          = 1'b1;
                    {m_addr_d, m_rw_d, m_data_d} = mem_q[rd_ptr_q];
                    m_en_d                       = 1'b1;
                    timer_d                      = '0;
                    state_d                      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (timer_q == TLAST) begin
                    m_en_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_rw_d    = m_rw_q;
                    rsp_to_d    = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (!m_ready) begin
                        m_en_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A completion seen on the final timer cycle still counts as success
                if (m_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m_rw_q ? m_data_out : 8'h00;
                    rsp_rw_d    = m_rw_q;
                    rsp_to_d    = 1'b0;
                    state_d     = ST_RESP;
                end else if (timer_q == TLAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_rw_d    = m_rw_q;
                    rsp_to_d    = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue FSM state, timer and registered master/response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_data_q    <= '0;
            m_en_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rw_q    <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_data_q    <= m_data_d;
            m_en_q      <= m_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural master model.
// The master returns {0,addr}^0x76 for reads and junk data for writes.
module tb_i2c_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_rw;
    logic       rsp_timeout;
    logic       busy;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic [7:0] m_data_out = '0;
    logic       m_ready = 1'b1;

    i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rw(rsp_rw), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
        .m_data_out(m_data_out), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic [7:0] e_data;
        logic       e_rw;
        logic       e_to;
    } vec_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    cmd_t issue_q[$];
    cmd_t cur;
    bit   engaged = 1'b0;
    bit   mstuck  = 1'b0;
    bit   mbusy   = 1'b0;
    int   mcnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] slave_byte(input logic [6:0] a);
        return {1'b0, a} ^ 8'h76;
    endfunction

    // Master model: acts on values settled 1 time unit after each rising edge
    always begin
        @(posedge clk); #1;
        if (!rst) begin
            m_ready = 1'b1;
            engaged = 1'b0;
        end else if (mstuck) begin
            m_ready = 1'b1;
            engaged = 1'b0;
        end else if (engaged) begin
            chk("pins stable in RUN", 32'({m_addr, m_rw, m_data_in}), 32'(cur));
            chk("enable low in RUN", 32'(m_enable), 32'd0);
            if (mcnt > 0) begin
                mcnt--;
            end else begin
                m_data_out = cur.rw ? slave_byte(cur.addr) : 8'hEE;
                m_ready    = 1'b1;
                engaged    = 1'b0;
            end
        end else if (m_ready && m_enable) begin
            if (issue_q.size() == 0) begin
                chk("unexpected issue", 32'd1, 32'd0);
                cur = '0;
            end else begin
                cur = issue_q.pop_front();
            end
            chk("issue pins", 32'({m_addr, m_rw, m_data_in}), 32'(cur));
            engaged = 1'b1;
            mcnt    = 3;
            m_ready = 1'b0;
        end else begin
            m_ready = !mbusy;
        end
    end

    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] d);
        int   n = 0;
        cmd_t c;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd accepted", 32'(cmd_ready), 32'd1);
        c = {a, rw, d};
        issue_q.push_back(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input logic [7:0] ed, input logic erw, input logic eto);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " rsp_data"}, 32'(rsp_data), 32'(ed));
        chk({nm, " rsp_rw"}, 32'(rsp_rw), 32'(erw));
        chk({nm, " rsp_timeout"}, 32'(rsp_timeout), 32'(eto));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        cmd_t       q3[5];
        logic [7:0] e3[5];

        vecs[0] = '{7'h2A, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{7'h2A, 1'b1, 8'h00, 8'h5C, 1'b1, 1'b0};
        vecs[2] = '{7'h11, 1'b1, 8'hFF, 8'h67, 1'b1, 1'b0};
        vecs[3] = '{7'h7F, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{7'h00, 1'b1, 8'h3C, 8'h76, 1'b1, 1'b0};
        vecs[5] = '{7'h40, 1'b1, 8'h00, 8'h36, 1'b1, 1'b0};

        q3[0] = {7'h01, 1'b0, 8'h10}; e3[0] = 8'h00;
        q3[1] = {7'h02, 1'b1, 8'h20}; e3[1] = 8'h74;
        q3[2] = {7'h03, 1'b0, 8'h30}; e3[2] = 8'h00;
        q3[3] = {7'h04, 1'b1, 8'h40}; e3[3] = 8'h72;
        q3[4] = {7'h05, 1'b1, 8'h50}; e3[4] = 8'h73;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset outputs", 32'({rsp_valid, busy, m_enable, rsp_data, rsp_timeout, m_addr}), 32'd0);
        rst = 1'b1;
        #1;
        chk("cmd_ready before first edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("cmd_ready after release", 32'(cmd_ready), 32'd1);
        chk("busy idle", 32'(busy), 32'd0);

        // Table-driven single commands
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].addr, vecs[i].rw, vecs[i].data);
            @(posedge clk); #1;
            chk("enable one cycle after accept", 32'(m_enable), 32'd1);
            chk("issued addr", 32'(m_addr), 32'(vecs[i].addr));
            collect("vec", vecs[i].e_data, vecs[i].e_rw, vecs[i].e_to);
        end

        // Full FIFO with a busy master, then drain in order
        mbusy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(q3[i].addr, q3[i].rw, q3[i].data);
        chk("full cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_addr  = q3[4].addr;
        cmd_rw    = q3[4].rw;
        cmd_data  = q3[4].data;
        repeat (3) @(posedge clk);
        #1;
        chk("held off cmd_ready", 32'(cmd_ready), 32'd0);
        chk("no issue while master busy", 32'({m_enable, busy}), 32'b01);
        mbusy = 1'b0;
        send(q3[4].addr, q3[4].rw, q3[4].data);
        for (int i = 0; i < 5; i++) collect("ordered", e3[i], q3[i].rw, 1'b0);

        // Timeout with master never leaving idle
        mstuck = 1'b1;
        send(7'h19, 1'b0, 8'hC3);
        send(7'h2B, 1'b1, 8'h00);
        chk("timeout launch enable", 32'({m_enable, m_addr}), 32'({1'b1, 7'h19}));
        repeat (15) @(posedge clk);
        #1;
        chk("enable held 16th cycle", 32'({m_enable, rsp_valid}), 32'b10);
        @(posedge clk); #1;
        chk("timeout enable low", 32'(m_enable), 32'd0);
        void'(issue_q.pop_front());
        chk("timeout rsp", 32'({rsp_valid, rsp_timeout, rsp_rw, rsp_data}), 32'({3'b110, 8'h00}));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        mstuck    = 1'b0;
        chk("after timeout handshake", 32'({rsp_valid, m_enable}), 32'd0);
        @(posedge clk); #1;
        chk("next cmd issues", 32'({m_enable, m_addr}), 32'({1'b1, 7'h2B}));
        collect("after timeout", 8'h5D, 1'b1, 1'b0);

        // Response backpressure with two commands queued
        send(7'h15, 1'b1, 8'h00);
        send(7'h22, 1'b0, 8'h99);
        send(7'h33, 1'b1, 8'h00);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            chk("stalled rsp stable", 32'({rsp_valid, rsp_rw, rsp_timeout, rsp_data, m_enable}),
                32'({3'b110, 8'h63, 1'b0}));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("enable low at handshake", 32'(m_enable), 32'd0);
        @(posedge clk); #1;
        chk("second cmd after handshake", 32'({m_enable, m_addr}), 32'({1'b1, 7'h22}));
        collect("stall second", 8'h00, 1'b0, 1'b0);
        collect("stall third", 8'h45, 1'b1, 1'b0);

        // Reset in the middle of RUN with one command still queued
        send(7'h0A, 1'b1, 8'h00);
        send(7'h0B, 1'b0, 8'h77);
        @(posedge clk); #1;
        chk("in RUN before reset", 32'({busy, m_enable}), 32'b10);
        rst = 1'b0;
        issue_q.delete();
        #1;
        chk("async reset outputs",
            32'({m_enable, rsp_valid, busy, cmd_ready, m_addr, m_rw, m_data_in}), 32'd0);
        @(posedge clk); #1;
        chk("cmd_ready in reset", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("after reset", 32'({cmd_ready, busy, m_enable}), 32'b100);
        repeat (5) @(posedge clk);
        #1;
        chk("fifo empty after reset", 32'({busy, m_enable, rsp_valid}), 32'd0);
        send(7'h2A, 1'b1, 8'h00);
        collect("post reset", 8'h5C, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
